// File: rtl/scoreboard_stall_unit.sv
// Register scoreboard and pipeline stall generator: tracks registers awaiting
// long-latency writeback and detects load-use, RAW and WAW hazards in decode.
module scoreboard_stall_unit #(
  parameter int REG_INDEX_WIDTH   = 5,
  parameter int NUM_READ_PORTS    = 2,
  parameter int STALL_COUNT_WIDTH = 16,
  localparam int NUM_REGS         = 2 ** REG_INDEX_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rstN,
  input  logic [NUM_READ_PORTS*REG_INDEX_WIDTH-1:0] decodeReadRegisterIndices,
  input  logic [NUM_READ_PORTS-1:0]                 decodeReadRegisterValid,
  input  logic                                      decodeIsValid,
  input  logic [REG_INDEX_WIDTH-1:0]                decodeWriteRegisterIndex,
  input  logic                                      decodeIsLongLatencyOperation,
  input  logic [REG_INDEX_WIDTH-1:0]                executionStageWriteRegisterIndex,
  input  logic                                      isExecutionStageMemoryReadOperation,
  input  logic                                      longLatencyWritebackValid,
  input  logic [REG_INDEX_WIDTH-1:0]                longLatencyWritebackRegisterIndex,
  output logic                                      isPipelineStalled,
  output logic [1:0]                                stallCause,
  output logic [NUM_REGS-1:0]                       pendingRegisterMask,
  output logic [STALL_COUNT_WIDTH-1:0]              stalledCycleCount
);

  localparam logic [REG_INDEX_WIDTH-1:0]   REG_ZERO  = {REG_INDEX_WIDTH{1'b0}};
  localparam logic [STALL_COUNT_WIDTH-1:0] COUNT_ONE = {{(STALL_COUNT_WIDTH-1){1'b0}}, 1'b1};

  // x0 is hardwired: it never participates in any hazard or pending state.
  function automatic logic isNonZero(input logic [REG_INDEX_WIDTH-1:0] idx);
    return (idx != REG_ZERO);
  endfunction

  logic [NUM_REGS-1:0]          pendingMask_r;
  logic [NUM_REGS-1:0]          nextMask_s;
  logic [NUM_REGS-1:0]          effPending_s;
  logic [STALL_COUNT_WIDTH-1:0] stallCount_r;
  logic [STALL_COUNT_WIDTH-1:0] nextCount_s;
  logic                         loadUse_s;
  logic                         raw_s;
  logic                         waw_s;
  logic                         stall_s;
  logic [1:0]                   cause_s;
  logic                         issue_s;

  // Effective pending set: a writeback landing this cycle already satisfies its consumer.
  always_comb begin
    effPending_s = pendingMask_r;
    if (longLatencyWritebackValid) begin
      effPending_s[longLatencyWritebackRegisterIndex] = 1'b0;
    end else begin
      effPending_s = pendingMask_r;
    end
  end

  // Hazard detection and cause encoding (load-use > RAW > WAW).
  always_comb begin
    loadUse_s = 1'b0;
    raw_s     = 1'b0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      loadUse_s = loadUse_s
                | (decodeReadRegisterValid[p]
                   & isNonZero(decodeReadRegisterIndices[p*REG_INDEX_WIDTH +: REG_INDEX_WIDTH])
                   & isExecutionStageMemoryReadOperation
                   & (decodeReadRegisterIndices[p*REG_INDEX_WIDTH +: REG_INDEX_WIDTH]
                      == executionStageWriteRegisterIndex));
      raw_s = raw_s
            | (decodeIsValid
               & decodeReadRegisterValid[p]
               & isNonZero(decodeReadRegisterIndices[p*REG_INDEX_WIDTH +: REG_INDEX_WIDTH])
               & effPending_s[decodeReadRegisterIndices[p*REG_INDEX_WIDTH +: REG_INDEX_WIDTH]]);
    end
    waw_s = decodeIsValid & isNonZero(decodeWriteRegisterIndex)
          & effPending_s[decodeWriteRegisterIndex];
    stall_s = loadUse_s | raw_s | waw_s;
    if (loadUse_s) begin
      cause_s = 2'b01;
    end else if (raw_s) begin
      cause_s = 2'b10;
    end else if (waw_s) begin
      cause_s = 2'b11;
    end else begin
      cause_s = 2'b00;
    end
  end

  // Next scoreboard state: clear on writeback, then set on issue so a same-edge issue wins.
  always_comb begin
    issue_s = decodeIsValid & decodeIsLongLatencyOperation & ~stall_s
            & isNonZero(decodeWriteRegisterIndex);
    nextMask_s = pendingMask_r;
    if (longLatencyWritebackValid) begin
      nextMask_s[longLatencyWritebackRegisterIndex] = 1'b0;
    end else begin
      nextMask_s = pendingMask_r;
    end
    if (issue_s) begin
      nextMask_s[decodeWriteRegisterIndex] = 1'b1;
    end else begin
      nextMask_s[0] = 1'b0;
    end
    nextMask_s[0] = 1'b0;
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    if (stall_s && !(&stallCount_r)) begin
      nextCount_s = stallCount_r + COUNT_ONE;
    end else begin
      nextCount_s = stallCount_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pendingMask_r <= {NUM_REGS{1'b0}};
      stallCount_r  <= {STALL_COUNT_WIDTH{1'b0}};
    end else begin
      pendingMask_r <= nextMask_s;
      stallCount_r  <= nextCount_s;
    end
  end

  assign isPipelineStalled   = stall_s;
  assign stallCause          = cause_s;
  assign pendingRegisterMask = pendingMask_r;
  assign stalledCycleCount   = stallCount_r;

endmodule

// File: tb/tb_scoreboard_stall_unit.sv
// Scoreboard-style bench for scoreboard_stall_unit: each step queues its expected
// outputs, and the expectation is popped and compared once the outputs settle.
module tb_scoreboard_stall_unit;

  logic        clk;
  logic        rstN;
  logic [9:0]  decodeReadRegisterIndices;
  logic [1:0]  decodeReadRegisterValid;
  logic        decodeIsValid;
  logic [4:0]  decodeWriteRegisterIndex;
  logic        decodeIsLongLatencyOperation;
  logic [4:0]  executionStageWriteRegisterIndex;
  logic        isExecutionStageMemoryReadOperation;
  logic        longLatencyWritebackValid;
  logic [4:0]  longLatencyWritebackRegisterIndex;
  logic        isPipelineStalled;
  logic [1:0]  stallCause;
  logic [31:0] pendingRegisterMask;
  logic [15:0] stalledCycleCount;
  logic        stall2;
  logic [1:0]  cause2;
  logic [31:0] mask2;
  logic [3:0]  count2;

  typedef struct {
    string       name;
    logic [50:0] val;
  } exp_t;

  exp_t        expQ[$];
  logic [3:0]  cntQ[$];
  logic [15:0] expCount;
  logic [50:0] obs;
  int          nChecks;
  int          nErrors;

  scoreboard_stall_unit dut (
    .clk(clk), .rstN(rstN),
    .decodeReadRegisterIndices(decodeReadRegisterIndices),
    .decodeReadRegisterValid(decodeReadRegisterValid),
    .decodeIsValid(decodeIsValid),
    .decodeWriteRegisterIndex(decodeWriteRegisterIndex),
    .decodeIsLongLatencyOperation(decodeIsLongLatencyOperation),
    .executionStageWriteRegisterIndex(executionStageWriteRegisterIndex),
    .isExecutionStageMemoryReadOperation(isExecutionStageMemoryReadOperation),
    .longLatencyWritebackValid(longLatencyWritebackValid),
    .longLatencyWritebackRegisterIndex(longLatencyWritebackRegisterIndex),
    .isPipelineStalled(isPipelineStalled),
    .stallCause(stallCause),
    .pendingRegisterMask(pendingRegisterMask),
    .stalledCycleCount(stalledCycleCount)
  );

  scoreboard_stall_unit #(.STALL_COUNT_WIDTH(4)) dutNarrow (
    .clk(clk), .rstN(rstN),
    .decodeReadRegisterIndices(decodeReadRegisterIndices),
    .decodeReadRegisterValid(decodeReadRegisterValid),
    .decodeIsValid(decodeIsValid),
    .decodeWriteRegisterIndex(decodeWriteRegisterIndex),
    .decodeIsLongLatencyOperation(decodeIsLongLatencyOperation),
    .executionStageWriteRegisterIndex(executionStageWriteRegisterIndex),
    .isExecutionStageMemoryReadOperation(isExecutionStageMemoryReadOperation),
    .longLatencyWritebackValid(longLatencyWritebackValid),
    .longLatencyWritebackRegisterIndex(longLatencyWritebackRegisterIndex),
    .isPipelineStalled(stall2),
    .stallCause(cause2),
    .pendingRegisterMask(mask2),
    .stalledCycleCount(count2)
  );

  assign obs = {isPipelineStalled, stallCause, pendingRegisterMask, stalledCycleCount};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic setIn(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] rv,
                       input logic dv, input logic [4:0] wr, input logic lng,
                       input logic [4:0] exi, input logic exl,
                       input logic wbv, input logic [4:0] wbi);
    decodeReadRegisterIndices           = {r1, r0};
    decodeReadRegisterValid             = rv;
    decodeIsValid                       = dv;
    decodeWriteRegisterIndex            = wr;
    decodeIsLongLatencyOperation        = lng;
    executionStageWriteRegisterIndex    = exi;
    isExecutionStageMemoryReadOperation = exl;
    longLatencyWritebackValid           = wbv;
    longLatencyWritebackRegisterIndex   = wbi;
  endtask

  task automatic idle();
    setIn(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic pushExp(input string name, input logic s, input logic [1:0] c,
                         input logic [31:0] m);
    exp_t e;
    e.name = name;
    e.val  = {s, c, m, expCount};
    expQ.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      case (i)
        0: begin idle(); pushExp("reset_idle", 1'b0, 2'b00, 32'h0); end
        1: begin
          setIn(5'd0, 5'd5, 2'b10, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0);
          pushExp("reset_loaduse", 1'b1, 2'b01, 32'h0);
        end
        default: begin
          setIn(5'd7, 5'd0, 2'b01, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
          pushExp("reset_noissue", 1'b0, 2'b00, 32'h0);
        end
      endcase
      #1;
      e = expQ.pop_front();
      nChecks++;
      if (obs !== e.val) begin
        nErrors++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      end
    end
    @(negedge clk);
    idle();
    rstN = 1'b1;
    expCount = 16'd0;
  endtask

  task automatic test_load_use();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      case (i)
        0: begin
          setIn(5'd0, 5'd5, 2'b10, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0);
          pushExp("lu_x5_port1", 1'b1, 2'b01, 32'h0);
        end
        1: begin
          setIn(5'd0, 5'd0, 2'b11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0);
          pushExp("lu_x0", 1'b0, 2'b00, 32'h0);
        end
        2: begin
          setIn(5'd0, 5'd5, 2'b01, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0);
          pushExp("lu_invalid_port", 1'b0, 2'b00, 32'h0);
        end
        3: begin
          setIn(5'd5, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 5'd0);
          pushExp("lu_not_load", 1'b0, 2'b00, 32'h0);
        end
        default: begin
          setIn(5'd5, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0);
          pushExp("lu_x5_port0", 1'b1, 2'b01, 32'h0);
        end
      endcase
      #1;
      e = expQ.pop_front();
      nChecks++;
      if (obs !== e.val) begin
        nErrors++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      end
      if (e.val[50]) expCount = expCount + 16'd1;
    end
  endtask

  task automatic test_raw();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      case (i)
        0: begin
          setIn(5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
          pushExp("raw_issue_x7", 1'b0, 2'b00, 32'h0);
        end
        1, 2, 3: begin
          setIn(5'd7, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
          pushExp("raw_stall_x7", 1'b1, 2'b10, 32'h0000_0080);
        end
        4: begin
          setIn(5'd7, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7);
          pushExp("raw_wb_bypass", 1'b0, 2'b00, 32'h0000_0080);
        end
        default: begin idle(); pushExp("raw_cleared", 1'b0, 2'b00, 32'h0); end
      endcase
      #1;
      e = expQ.pop_front();
      nChecks++;
      if (obs !== e.val) begin
        nErrors++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs, e.val);
      end
      if (e.val[50]) expCount = expCount + 16'd1;
    end
  endtask

  task automatic test_waw();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      case (i)
        0: begin
          setIn(5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
          pushExp("waw_issue_x9", 1'b0, 2'b00, 32'h0);
        end
        1: begin
          setIn(5'd2, 5'd0, 2'b01, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
          pushExp("waw_stall_x9", 1'b1, 2'b11, 32'h0000_0200);
        end
        2: begin
          setIn(5'd2, 5'd9, 2'b01, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
          pushExp("waw_issue_x12", 1'b0, 2'b00, 32'h0000_0200);
        end
        3: begin
          setIn(5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
          pushExp("waw_multi_pending", 1'b1, 2'b11, 32'h0000_1200);
        end
        4: begin
          setIn(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9);
          pushExp("waw_wb_x9", 1'b0, 2'b00, 32'h0000_1200);
        end
        5: begin
          setIn(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12);
          pushExp("waw_wb_x12", 1'b0, 2'b00, 32'h0000_1000);
        end
        default: begin idle(); pushExp("waw_cleared", 1'b0, 2'b00, 32'h0); end
      endcase
      #1;
      e = expQ.pop_front();
      nChecks++;
      if (obs !== e.val) begin
        nErrors++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      end
      if (e.val[50]) expCount = expCount + 16'd1;
    end
  endtask

  task automatic test_priority_simultaneous();
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      case (i)
        0: begin
          setIn(5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
          pushExp("sim_issue_x3", 1'b0, 2'b00, 32'h0);
        end
        1: begin
          setIn(5'd3, 5'd4, 2'b11, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0);
          pushExp("prio_loaduse", 1'b1, 2'b01, 32'h0000_0008);
        end
        2: begin
          setIn(5'd3, 5'd0, 2'b01, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
          pushExp("prio_raw", 1'b1, 2'b10, 32'h0000_0008);
        end
        3: begin
          setIn(5'd0, 5'd0, 2'b11, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0);
          pushExp("x0_never_hazard", 1'b0, 2'b00, 32'h0000_0008);
        end
        4: begin
          setIn(5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3);
          pushExp("sim_wb_and_issue", 1'b0, 2'b00, 32'h0000_0008);
        end
        5: begin idle(); pushExp("sim_set_wins", 1'b0, 2'b00, 32'h0000_0008); end
        6: begin
          setIn(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3);
          pushExp("sim_wb_x3", 1'b0, 2'b00, 32'h0000_0008);
        end
        7: begin
          setIn(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3);
          pushExp("wb_not_pending", 1'b0, 2'b00, 32'h0);
        end
        default: begin idle(); pushExp("sim_final", 1'b0, 2'b00, 32'h0); end
      endcase
      #1;
      e = expQ.pop_front();
      nChecks++;
      if (obs !== e.val) begin
        nErrors++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      end
      if (e.val[50]) expCount = expCount + 16'd1;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      case (i)
        0: begin
          setIn(5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
          pushExp("ar_issue_x7", 1'b0, 2'b00, 32'h0);
        end
        1: begin
          setIn(5'd0, 5'd0, 2'b00, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
          pushExp("ar_issue_x10", 1'b0, 2'b00, 32'h0000_0080);
        end
        2: begin idle(); pushExp("ar_mask_0480", 1'b0, 2'b00, 32'h0000_0480); end
        3: begin
          idle();
          #1;
          rstN = 1'b0;
          expCount = 16'd0;
          pushExp("ar_cleared_async", 1'b0, 2'b00, 32'h0);
        end
        4: begin
          setIn(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7);
          pushExp("ar_late_wb_x7", 1'b0, 2'b00, 32'h0);
        end
        default: begin idle(); pushExp("ar_after_wb", 1'b0, 2'b00, 32'h0); end
      endcase
      #1;
      e = expQ.pop_front();
      nChecks++;
      if (obs !== e.val) begin
        nErrors++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      end
      if (i == 3) rstN = 1'b1;
      if (e.val[50]) expCount = expCount + 16'd1;
    end
  endtask

  task automatic test_counter_saturation();
    logic [3:0] want;
    @(negedge clk);
    rstN = 1'b0;
    #1;
    rstN = 1'b1;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      setIn(5'd0, 5'd5, 2'b10, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0);
      cntQ.push_back((i > 15) ? 4'd15 : 4'(i));
      #1;
      want = cntQ.pop_front();
      nChecks++;
      if (count2 !== want) begin
        nErrors++;
        $display("FAIL counter_sat cycle %0d: got %0d expected %0d", i, count2, want);
      end
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    nChecks  = 0;
    nErrors  = 0;
    expCount = 16'd0;
    rstN     = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_raw();
    test_waw();
    test_priority_simultaneous();
    test_async_reset();
    test_counter_saturation();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
